ext_unit: RTL and testbench
===========================

// Module: ext_unit
// PURPOSE
//   Immediate extender for the single-cycle MIPS datapath. Takes the 16-bit
//   instruction immediate and produces a 32-bit operand for the ALU, branch
//   offset adder or LUI path, selected by a 2-bit op code.
//   The result is registered: one-cycle latency, with a valid flag so the
//   downstream stage knows when the output is fresh.
// PARAMETERS
//   IMM_W   16  immediate width (fixed at 16; other values unsupported)
//   OUT_W   32  output width (fixed at 32; other values unsupported)
// PORTS
//   clk        in   1   system clock, rising-edge active
//   reset      in   1   synchronous, active-high reset
//   imm        in   16  raw immediate field
//   EOp        in   2   extension op select (encoding below)
//   in_valid   in   1   imm/EOp are meaningful this cycle
//   ext        out  32  extended result, registered
//   out_valid  out  1   ext holds the result of an accepted input
// BEHAVIOUR
//   - Single clock domain; all state updates on rising edge of clk.
//   - reset (sync, high) takes priority over everything else:
//     ext <= 32'h0000_0000, out_valid <= 0.
//   - EOp encoding (combinational core, f(imm,EOp)):
//       2'b00 sign-extend:     {{16{imm[15]}}, imm}
//       2'b01 zero-extend:     {16'h0000, imm}
//       2'b10 load-high (LUI): {imm, 16'h0000}
//       2'b11 branch offset:   {{14{imm[15]}}, imm, 2'b00}  (sign-ext then <<2)
//   - All four encodings are legal; no X-propagation case.
//   - Timing: if in_valid=1 at edge N, then after edge N ext=f(imm,EOp) and
//     out_valid=1. Latency exactly 1 cycle; one result accepted per cycle.
//   - If in_valid=0 at an edge: out_valid <= 0, ext holds its previous value.
//   - No backpressure: the output is overwritten every accepted cycle.
//   - Reset asserted in the same cycle as in_valid: reset wins; the input is
//     dropped, ext=0 and out_valid=0.
//   - First accepted input after reset release appears one cycle later.
//   - Pure width arithmetic; no overflow flags. Bit 1:0 of mode 11 are always 0.
// TESTING
//   - reset=1 for 2 cycles with in_valid=1, imm=16'hffff -> ext=0, out_valid=0.
//   - imm=16'hffff, in_valid=1, EOp 00/01/10/11 on consecutive cycles ->
//     ext=ffffffff, 0000ffff, ffff0000, fffffffc, one cycle after each.
//   - imm=16'h0000, EOp 00..11 -> ext=00000000 for all modes, out_valid=1.
//   - imm=16'h7fff: EOp 00 -> 00007fff; EOp 11 -> 0001fffc.
//     imm=16'h8000: EOp 00 -> ffff8000; EOp 11 -> fffe0000.
//   - in_valid=1 (imm=16'h1234, EOp=10) then in_valid=0 -> ext=12340000
//     holds, out_valid goes 1 then 0.
//   - reset pulsed mid-stream after ext=ffffffff -> next cycle ext=0,
//     out_valid=0; the next accepted input resumes normally.

Source files
------------

// File: rtl/ext_unit.sv
// Immediate extender for the MIPS datapath: 16-bit immediate to 32-bit operand,
// selected by EOp, registered with a one-cycle latency and a valid flag.
module ext_unit #(
    parameter int unsigned IMM_W = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IMM_W-1:0]     imm,
    input  logic [1:0]           EOp,
    input  logic                 in_valid,
    output logic [OUT_W-1:0]     ext,
    output logic                 out_valid
);

    localparam int unsigned HI_W  = OUT_W - IMM_W;
    localparam int unsigned BR_SH = 2;
    localparam int unsigned BR_W  = OUT_W - IMM_W - BR_SH;

    typedef enum logic [1:0] {
        EOP_SEXT = 2'b00,
        EOP_ZEXT = 2'b01,
        EOP_LUI  = 2'b10,
        EOP_BOFF = 2'b11
    } eop_e;

    logic [OUT_W-1:0] ext_c;
    logic             sign_c;

    // Combinational extension core
    always_comb begin
        ext_c  = '0;
        sign_c = imm[IMM_W-1];
        unique case (eop_e'(EOp))
            EOP_SEXT: ext_c = {{HI_W{sign_c}}, imm};
            EOP_ZEXT: ext_c = {{HI_W{1'b0}}, imm};
            EOP_LUI:  ext_c = {imm, {HI_W{1'b0}}};
            EOP_BOFF: ext_c = {{BR_W{sign_c}}, imm, {BR_SH{1'b0}}};
            default:  ext_c = '0;
        endcase
    end

    // Output register; ext holds its value across idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            ext       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ext <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_ext_unit.sv
// Bench for ext_unit: arithmetic reference model checked every cycle, plus
// literal expectations that pin both the DUT and the model.
module tb_ext_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic [31:0] ext;
    logic        out_valid;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_ext = 32'h0;
    logic        m_v   = 1'b0;

    always #5 clk = ~clk;

    ext_unit dut (
        .clk      (clk),
        .reset    (reset),
        .imm      (imm),
        .EOp      (eop),
        .in_valid (in_valid),
        .ext      (ext),
        .out_valid(out_valid)
    );

    // Reference built from integer arithmetic rather than bit concatenation
    function automatic logic [31:0] ref_f(input logic [15:0] i, input logic [1:0] op);
        int s;
        s = int'($signed(i));
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(i);
            2'd2:    return 32'(i) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    // One clock: apply inputs, advance the model at the edge, compare after it
    task automatic step(input logic r, input logic v, input logic [15:0] i, input logic [1:0] op);
        reset    = r;
        in_valid = v;
        imm      = i;
        eop      = op;
        @(posedge clk);
        if (r) begin
            m_ext = 32'h0;
            m_v   = 1'b0;
        end else begin
            m_v = v;
            if (v) m_ext = ref_f(i, op);
        end
        #1;
        total++;
        if (ext !== m_ext || out_valid !== m_v) begin
            bad++;
            $display("FAIL model: ext=%h out_valid=%b required ext=%h out_valid=%b (imm=%h op=%0d v=%b r=%b)",
                     ext, out_valid, m_ext, m_v, i, op, v, r);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] e, input logic ev);
        total++;
        if (ext !== e || out_valid !== ev) begin
            bad++;
            $display("FAIL %s: ext=%h out_valid=%b required ext=%h out_valid=%b", name, ext, out_valid, e, ev);
        end
        total++;
        if (m_ext !== e || m_v !== ev) begin
            bad++;
            $display("FAIL %s_model: model ext=%h valid=%b required ext=%h valid=%b", name, m_ext, m_v, e, ev);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        imm      = 16'h0;
        eop      = 2'd0;

        step(1'b1, 1'b1, 16'hffff, 2'd0);
        lit("reset0", 32'h0, 1'b0);
        step(1'b1, 1'b1, 16'hffff, 2'd3);
        lit("reset1", 32'h0, 1'b0);

        step(1'b0, 1'b1, 16'hffff, 2'd0); lit("ffff_sext", 32'hffff_ffff, 1'b1);
        step(1'b0, 1'b1, 16'hffff, 2'd1); lit("ffff_zext", 32'h0000_ffff, 1'b1);
        step(1'b0, 1'b1, 16'hffff, 2'd2); lit("ffff_lui",  32'hffff_0000, 1'b1);
        step(1'b0, 1'b1, 16'hffff, 2'd3); lit("ffff_boff", 32'hffff_fffc, 1'b1);

        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 16'h0000, 2'(k));
            lit("zero_imm", 32'h0, 1'b1);
        end

        step(1'b0, 1'b1, 16'h7fff, 2'd0); lit("7fff_sext", 32'h0000_7fff, 1'b1);
        step(1'b0, 1'b1, 16'h7fff, 2'd3); lit("7fff_boff", 32'h0001_fffc, 1'b1);
        step(1'b0, 1'b1, 16'h8000, 2'd0); lit("8000_sext", 32'hffff_8000, 1'b1);
        step(1'b0, 1'b1, 16'h8000, 2'd3); lit("8000_boff", 32'hfffe_0000, 1'b1);

        step(1'b0, 1'b1, 16'h1234, 2'd2); lit("hold_load", 32'h1234_0000, 1'b1);
        step(1'b0, 1'b0, 16'hdead, 2'd0); lit("hold_idle", 32'h1234_0000, 1'b0);
        step(1'b0, 1'b0, 16'hbeef, 2'd3); lit("hold_idle2", 32'h1234_0000, 1'b0);

        step(1'b0, 1'b1, 16'hffff, 2'd0); lit("pre_reset", 32'hffff_ffff, 1'b1);
        step(1'b1, 1'b1, 16'h1234, 2'd2); lit("mid_reset", 32'h0, 1'b0);
        step(1'b0, 1'b1, 16'h8000, 2'd1); lit("resume",    32'h0000_8000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 16'($urandom),
                 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
